// File: rtl/vin_pulsecounter_pkg.sv
// Shared definitions for the vin_pulsecounter gate sequencer: FSM encoding and
// saturation limit helpers parameterised by accumulator width.
package vin_pulsecounter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int COUNT_W_DEF = 16;
  localparam int GATE_W_DEF  = 32;

  // Largest positive value of a w-bit two's complement number
  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value of a w-bit two's complement number
  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/vin_pulsecounter_sync.sv
// Two-flop synchroniser plus rising-edge detector for one asynchronous pulse pin.
// evt is high for one cycle; the count lands on the third clk edge after the pin
// is first sampled high.
module vin_pulsecounter_sync (
  input  logic clk,
  input  logic RESET,
  input  logic pin,
  output logic evt
);

  logic s1, s2, s3;

  // Synchroniser chain with a trailing history flop for edge detection
  always_ff @(posedge clk) begin
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign evt = s2 & ~s3;

endmodule

// File: rtl/vin_pulsecounter_gate.sv
// Gate-time sequencer: counts synchronised UP/DOWN edges into a saturating signed
// accumulator over back-to-back windows of gate_cycles clocks and publishes one
// snapshot per window with a single-cycle valid strobe.
module vin_pulsecounter_gate
  import vin_pulsecounter_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int GATE_W  = GATE_W_DEF
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               enable,
  input  logic [GATE_W-1:0]  gate_cycles,
  input  logic               UP,
  input  logic               DOWN,
  output logic [COUNT_W-1:0] count_out,
  output logic               valid,
  output logic               overflow,
  output logic               busy
);

  localparam logic signed [COUNT_W:0] ACC_MAX = (COUNT_W + 1)'(sat_max(COUNT_W));
  localparam logic signed [COUNT_W:0] ACC_MIN = (COUNT_W + 1)'(sat_min(COUNT_W));
  localparam logic signed [COUNT_W:0] ONE     = (COUNT_W + 1)'(1);

  state_t                    state, state_nxt;
  logic [GATE_W-1:0]         gate_cnt;
  logic [GATE_W-1:0]         gate_load;
  logic signed [COUNT_W-1:0] acc;
  logic                      ovf;
  logic                      up_evt, dn_evt;
  logic signed [COUNT_W:0]   sum_ext;
  logic [COUNT_W-1:0]        acc_sat;
  logic                      clamp;
  logic                      last;

  vin_pulsecounter_sync u_sync_up (
    .clk   (clk),
    .RESET (RESET),
    .pin   (UP),
    .evt   (up_evt)
  );

  vin_pulsecounter_sync u_sync_dn (
    .clk   (clk),
    .RESET (RESET),
    .pin   (DOWN),
    .evt   (dn_evt)
  );

  // A zero window length still produces a one-cycle window
  assign gate_load = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
  assign last      = (state == COUNT) && enable && (gate_cnt == GATE_W'(1));
  assign busy      = (state != IDLE);

  // Next accumulator value, widened by one bit so clamping never wraps
  always_comb begin
    sum_ext = {acc[COUNT_W-1], acc};
    if (up_evt && !dn_evt)      sum_ext = sum_ext + ONE;
    else if (dn_evt && !up_evt) sum_ext = sum_ext - ONE;
    clamp   = 1'b0;
    acc_sat = sum_ext[COUNT_W-1:0];
    if (sum_ext > ACC_MAX) begin
      acc_sat = ACC_MAX[COUNT_W-1:0];
      clamp   = 1'b1;
    end else if (sum_ext < ACC_MIN) begin
      acc_sat = ACC_MIN[COUNT_W-1:0];
      clamp   = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; dropping enable aborts from any active state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = ARM;
      ARM:     state_nxt = enable ? COUNT : IDLE;
      COUNT:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gate counter, accumulator and published snapshot
  always_ff @(posedge clk) begin
    if (RESET) begin
      gate_cnt  <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (state == ARM) begin
        gate_cnt <= gate_load;
        acc      <= '0;
        ovf      <= 1'b0;
      end else if (last) begin
        // Window closes and the next one opens on the same edge
        count_out <= acc_sat;
        overflow  <= ovf | clamp;
        valid     <= 1'b1;
        acc       <= '0;
        ovf       <= 1'b0;
        gate_cnt  <= gate_load;
      end else if (state == COUNT && enable) begin
        acc      <= acc_sat;
        ovf      <= ovf | clamp;
        gate_cnt <= gate_cnt - GATE_W'(1);
      end
    end
  end

endmodule
